sm3_expnd_mw_core: RTL and testbench

Parametrised SM3 message-expansion core, next generation of the single-word expansion stage. It accepts padded 512-bit message blocks from the padding stage, 1 or 2 words per beat. It streams W_j and W'_j (j = 0..63) to the compression stage, 1 or 2 words per beat, with output back-pressure and optional protocol checking.

---
 rtl/sm3_expnd_pkg.sv | 27 ++
 rtl/sm3_expnd_mw_core_if.sv | 35 +++
 rtl/sm3_expnd_wgen.sv | 19 +
 rtl/sm3_expnd_mw_core.sv | 161 ++++++++++++++++
 tb/tb_sm3_expnd_mw_core.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm3_expnd_pkg.sv
// sm3_expnd_pkg
//   Shared constants, FSM state type and word-level helpers for the SM3
//   message-expansion core.
//   SM3_WORD_W   : word width in bits
//   SM3_BLK_WN   : words per message block (window depth)
//   SM3_EXPND_WN : expanded W_j words produced per block
package sm3_expnd_pkg;

    localparam int SM3_WORD_W   = 32;
    localparam int SM3_BLK_WN   = 16;
    localparam int SM3_EXPND_WN = 64;

    typedef enum logic {
        LOAD  = 1'b0,
        EXPND = 1'b1
    } state_e;

    function automatic logic [SM3_WORD_W-1:0] rotl32(input logic [SM3_WORD_W-1:0] x,
                                                     input int unsigned           n);
        return (x << n) | (x >> (SM3_WORD_W - n));
    endfunction

    function automatic logic [SM3_WORD_W-1:0] p1(input logic [SM3_WORD_W-1:0] x);
        return x ^ rotl32(x, 15) ^ rotl32(x, 23);
    endfunction

endpackage

// File: rtl/sm3_expnd_mw_core_if.sv
// sm3_expnd_mw_core_if
//   Handshake bundle between the padding stage, the expansion core and the
//   compression stage.
//   Parameters: INPT_WN / OTPT_WN words per input / output beat.
//   master : padding/compression side (drives input beats and ena)
//   slave  : expansion core
interface sm3_expnd_mw_core_if
    import sm3_expnd_pkg::*;
#(
    parameter int INPT_WN = 1,
    parameter int OTPT_WN = 1
);
    logic [SM3_WORD_W*INPT_WN-1:0] pad_inpt_d_i;
    logic                          pad_inpt_vld_i;
    logic                          pad_inpt_lst_i;
    logic                          pad_inpt_rdy_o;
    logic                          expnd_otpt_ena_i;
    logic                          expnd_otpt_vld_o;
    logic [SM3_WORD_W*OTPT_WN-1:0] expnd_otpt_wj_o;
    logic [SM3_WORD_W*OTPT_WN-1:0] expnd_otpt_wjj_o;
    logic [5:0]                    expnd_otpt_idx_o;
    logic                          expnd_otpt_lst_o;

    modport master (
        output pad_inpt_d_i, pad_inpt_vld_i, pad_inpt_lst_i, expnd_otpt_ena_i,
        input  pad_inpt_rdy_o, expnd_otpt_vld_o, expnd_otpt_wj_o, expnd_otpt_wjj_o,
               expnd_otpt_idx_o, expnd_otpt_lst_o
    );

    modport slave (
        input  pad_inpt_d_i, pad_inpt_vld_i, pad_inpt_lst_i, expnd_otpt_ena_i,
        output pad_inpt_rdy_o, expnd_otpt_vld_o, expnd_otpt_wj_o, expnd_otpt_wjj_o,
               expnd_otpt_idx_o, expnd_otpt_lst_o
    );
endinterface

// File: rtl/sm3_expnd_wgen.sv
// sm3_expnd_wgen
//   Combinational generator of one expanded word
//   W_n = P1(W_{n-16} ^ W_{n-9} ^ (W_{n-3} <<< 15)) ^ (W_{n-13} <<< 7) ^ W_{n-6}
//   Ports: w_m16_i, w_m13_i, w_m9_i, w_m6_i, w_m3_i -> window taps
//          w_n_o                                    -> new word
module sm3_expnd_wgen
    import sm3_expnd_pkg::*;
(
    input  logic [SM3_WORD_W-1:0] w_m16_i,
    input  logic [SM3_WORD_W-1:0] w_m13_i,
    input  logic [SM3_WORD_W-1:0] w_m9_i,
    input  logic [SM3_WORD_W-1:0] w_m6_i,
    input  logic [SM3_WORD_W-1:0] w_m3_i,
    output logic [SM3_WORD_W-1:0] w_n_o
);

    assign w_n_o = p1(w_m16_i ^ w_m9_i ^ rotl32(w_m3_i, 15)) ^ rotl32(w_m13_i, 7) ^ w_m6_i;

endmodule

// File: rtl/sm3_expnd_mw_core.sv
// sm3_expnd_mw_core
//   SM3 message expansion: loads a 16-word block INPT_WN words per beat and
//   streams W_j / W'_j (j = 0..63) OTPT_WN words per beat with back-pressure.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     bus (slave)  : padding-stage input and compression-stage output handshakes
//     expnd_err_o  : sticky protocol error, only when SM3_EXPND_ERR_CHK_EN is
//                    defined (from sm3_cfg.v)
//
//   state | meaning
//   LOAD  | accepting input words into the window, rdy = 1
//   EXPND | presenting W_j..W_{j+OTPT_WN-1}, vld = 1, shifting on ena
module sm3_expnd_mw_core
    import sm3_expnd_pkg::*;
#(
    parameter int INPT_WN = 1,
    parameter int OTPT_WN = 1
)(
    input  logic                 clk,
    input  logic                 rst,
    sm3_expnd_mw_core_if.slave   bus
`ifdef SM3_EXPND_ERR_CHK_EN
    ,
    output logic                 expnd_err_o
`endif
);

    localparam int         INPT_DW = SM3_WORD_W * INPT_WN;
    localparam int         OTPT_DW = SM3_WORD_W * OTPT_WN;
    localparam logic [4:0] IN_STEP = 5'(INPT_WN);
    localparam logic [4:0] BLK_CNT = 5'(SM3_BLK_WN);
    localparam logic [5:0] OT_STEP = 6'(OTPT_WN);
    localparam logic [5:0] J_LAST  = 6'(SM3_EXPND_WN - OTPT_WN);

    state_e                state_q, state_d;
    logic [SM3_WORD_W-1:0] win_q [SM3_BLK_WN];
    logic [SM3_WORD_W-1:0] win_d [SM3_BLK_WN];
    logic [5:0]            j_q, j_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  lst_q, lst_d;

    logic [SM3_WORD_W-1:0] gen_w [OTPT_WN];
    logic                  in_hs, out_hs, blk_done;
    logic [OTPT_DW-1:0]    wj, wjj;

    // Every generated word depends only on the current window, so the two
    // generators for OTPT_WN = 2 run in parallel without chaining.
    for (genvar g = 0; g < OTPT_WN; g++) begin : g_wgen
        sm3_expnd_wgen u_wgen (
            .w_m16_i (win_q[g]),
            .w_m13_i (win_q[g+3]),
            .w_m9_i  (win_q[g+7]),
            .w_m6_i  (win_q[g+10]),
            .w_m3_i  (win_q[g+13]),
            .w_n_o   (gen_w[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            for (int i = 0; i < SM3_BLK_WN; i++) win_q[i] <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            lst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            lst_q   <= lst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        j_d      = j_q;
        cnt_d    = cnt_q;
        lst_d    = lst_q;
        in_hs    = (state_q == LOAD) & bus.pad_inpt_vld_i;
        out_hs   = (state_q == EXPND) & bus.expnd_otpt_ena_i;
        blk_done = in_hs & ((cnt_q + IN_STEP) == BLK_CNT);

        case (state_q)
            LOAD: begin
                if (in_hs) begin
                    // MS input lane carries the lower word index, so it lands first.
                    for (int i = 0; i < SM3_BLK_WN - INPT_WN; i++) win_d[i] = win_q[i+INPT_WN];
                    for (int m = 0; m < INPT_WN; m++)
                        win_d[SM3_BLK_WN-INPT_WN+m] = bus.pad_inpt_d_i[INPT_DW-1-SM3_WORD_W*m -: SM3_WORD_W];
                    cnt_d = cnt_q + IN_STEP;
                    if (blk_done) begin
                        lst_d   = bus.pad_inpt_lst_i;
                        j_d     = '0;
                        state_d = EXPND;
                    end
                end
            end
            EXPND: begin
                if (out_hs) begin
                    for (int i = 0; i < SM3_BLK_WN - OTPT_WN; i++) win_d[i] = win_q[i+OTPT_WN];
                    for (int m = 0; m < OTPT_WN; m++) win_d[SM3_BLK_WN-OTPT_WN+m] = gen_w[m];
                    j_d = j_q + OT_STEP;
                    if (j_q == J_LAST) begin
                        j_d     = '0;
                        cnt_d   = '0;
                        lst_d   = 1'b0;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Data outputs read zero outside EXPND.
    always_comb begin
        wj  = '0;
        wjj = '0;
        if (state_q == EXPND) begin
            for (int k = 0; k < OTPT_WN; k++) begin
                wj [OTPT_DW-1-SM3_WORD_W*k -: SM3_WORD_W] = win_q[k];
                wjj[OTPT_DW-1-SM3_WORD_W*k -: SM3_WORD_W] = win_q[k] ^ win_q[k+4];
            end
        end
    end

    assign bus.pad_inpt_rdy_o   = (state_q == LOAD);
    assign bus.expnd_otpt_vld_o = (state_q == EXPND);
    assign bus.expnd_otpt_wj_o  = wj;
    assign bus.expnd_otpt_wjj_o = wjj;
    assign bus.expnd_otpt_idx_o = j_q;
    assign bus.expnd_otpt_lst_o = lst_q & (j_q == J_LAST) & (state_q == EXPND);

`ifdef SM3_EXPND_ERR_CHK_EN
    logic err_q, err_d;
    logic vld_prev_q, vld_prev_d;

    // A gap inside a block is tolerated by the datapath but still reported.
    always_comb begin
        vld_prev_d = bus.pad_inpt_vld_i;
        err_d      = err_q
                   | (in_hs & bus.pad_inpt_lst_i & ~blk_done)
                   | ((state_q == LOAD) & vld_prev_q & ~bus.pad_inpt_vld_i & (cnt_q != 5'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            vld_prev_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            vld_prev_q <= vld_prev_d;
        end
    end

    assign expnd_err_o = err_q;
`endif

endmodule

// File: tb/tb_sm3_expnd_mw_core.sv
module tb_sm3_expnd_mw_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    sm3_expnd_mw_core_if #(.INPT_WN(1), .OTPT_WN(1)) bus1 ();
    sm3_expnd_mw_core_if #(.INPT_WN(2), .OTPT_WN(2)) bus2 ();

`ifdef SM3_EXPND_ERR_CHK_EN
    logic err1, err2;
    sm3_expnd_mw_core #(.INPT_WN(1), .OTPT_WN(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1), .expnd_err_o(err1));
    sm3_expnd_mw_core #(.INPT_WN(2), .OTPT_WN(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2), .expnd_err_o(err2));
`else
    sm3_expnd_mw_core #(.INPT_WN(1), .OTPT_WN(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    sm3_expnd_mw_core #(.INPT_WN(2), .OTPT_WN(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
`endif

    typedef struct {
        logic [5:0]  idx;
        logic [63:0] wj;
        logic [63:0] wjj;
        logic        lst;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] blk   [16];
    logic [31:0] ref_w [68];

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] ref_p1(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic build_ref();
        for (int i = 0; i < 16; i++) ref_w[i] = blk[i];
        for (int n = 16; n < 68; n++)
            ref_w[n] = ref_p1(ref_w[n-16] ^ ref_w[n-9] ^ rl(ref_w[n-3], 15)) ^ rl(ref_w[n-13], 7) ^ ref_w[n-6];
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic push1(input logic lst_blk);
        exp_t e;
        for (int j = 0; j < 64; j++) begin
            e.idx = 6'(j);
            e.wj  = {32'h0, ref_w[j]};
            e.wjj = {32'h0, ref_w[j] ^ ref_w[j+4]};
            e.lst = lst_blk && (j == 63);
            q1.push_back(e);
        end
    endtask

    task automatic push2(input logic lst_blk);
        exp_t e;
        for (int j = 0; j < 64; j += 2) begin
            e.idx = 6'(j);
            e.wj  = {ref_w[j], ref_w[j+1]};
            e.wjj = {ref_w[j] ^ ref_w[j+4], ref_w[j+1] ^ ref_w[j+5]};
            e.lst = lst_blk && (j == 62);
            q2.push_back(e);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the 16th word.
    task automatic load1(input logic lst_blk, input logic gap, input int early_lst);
        chk("load1_rdy", {63'h0, bus1.pad_inpt_rdy_o}, 64'd1);
        for (int w = 0; w < 16; w++) begin
            if (gap && (w % 3 == 1)) begin
                bus1.pad_inpt_vld_i = 1'b0;
                bus1.pad_inpt_d_i   = 32'hdeadbeef;
                bus1.pad_inpt_lst_i = 1'b1;
                @(negedge clk);
                chk("gap_vld", {63'h0, bus1.expnd_otpt_vld_o}, 64'd0);
            end
            bus1.pad_inpt_vld_i = 1'b1;
            bus1.pad_inpt_d_i   = blk[w];
            bus1.pad_inpt_lst_i = (w == 15) ? lst_blk : (w == early_lst);
            @(negedge clk);
`ifdef SM3_EXPND_ERR_CHK_EN
            if (w == early_lst) chk("err_rise", {63'h0, err1}, 64'd1);
`endif
        end
        bus1.pad_inpt_vld_i = 1'b0;
        bus1.pad_inpt_lst_i = 1'b0;
        bus1.pad_inpt_d_i   = '0;
        chk("load1_vld_latency", {63'h0, bus1.expnd_otpt_vld_o}, 64'd1);
        chk("load1_rdy_low", {63'h0, bus1.pad_inpt_rdy_o}, 64'd0);
    endtask

    task automatic load2(input logic lst_blk);
        for (int b = 0; b < 8; b++) begin
            bus2.pad_inpt_vld_i = 1'b1;
            bus2.pad_inpt_d_i   = {blk[2*b], blk[2*b+1]};
            bus2.pad_inpt_lst_i = (b == 7) ? lst_blk : 1'b0;
            @(negedge clk);
        end
        bus2.pad_inpt_vld_i = 1'b0;
        bus2.pad_inpt_lst_i = 1'b0;
        bus2.pad_inpt_d_i   = '0;
        chk("load2_vld_latency", {63'h0, bus2.expnd_otpt_vld_o}, 64'd1);
    endtask

    // Compares the presented beat every cycle, so held beats must stay stable.
    task automatic drain1(input logic rnd, input logic spot, input int abort_idx);
        exp_t e;
        int   budget = 0;
        while (q1.size() > 0 && budget < 2000) begin
            e = q1[0];
            if (abort_idx >= 0 && int'(e.idx) == abort_idx) begin
                chk("abort_idx", {58'h0, bus1.expnd_otpt_idx_o}, {58'h0, e.idx});
                break;
            end
            chk("vld1", {63'h0, bus1.expnd_otpt_vld_o}, 64'd1);
            chk("rdy1_low", {63'h0, bus1.pad_inpt_rdy_o}, 64'd0);
            chk("idx1", {58'h0, bus1.expnd_otpt_idx_o}, {58'h0, e.idx});
            chk("wj1", {32'h0, bus1.expnd_otpt_wj_o}, e.wj);
            chk("wjj1", {32'h0, bus1.expnd_otpt_wjj_o}, e.wjj);
            chk("lst1", {63'h0, bus1.expnd_otpt_lst_o}, {63'h0, e.lst});
            if (spot) begin
                if (e.idx == 6'd16) chk("abc_w16", {32'h0, bus1.expnd_otpt_wj_o}, 64'h9092e200);
                if (e.idx == 6'd18) chk("abc_w18", {32'h0, bus1.expnd_otpt_wj_o}, 64'h000c0606);
                if (e.idx == 6'd12) chk("abc_wjj12", {32'h0, bus1.expnd_otpt_wjj_o}, 64'h9092e200);
                if (e.idx == 6'd0)  chk("abc_wjj0", {32'h0, bus1.expnd_otpt_wjj_o}, 64'h61626380);
            end
            bus1.expnd_otpt_ena_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus1.expnd_otpt_ena_i) void'(q1.pop_front());
            @(negedge clk);
            budget++;
        end
        bus1.expnd_otpt_ena_i = 1'b0;
        if (abort_idx < 0) begin
            chk("drain1_done", 64'(q1.size()), 64'd0);
            chk("drain1_rdy", {63'h0, bus1.pad_inpt_rdy_o}, 64'd1);
            chk("drain1_vld", {63'h0, bus1.expnd_otpt_vld_o}, 64'd0);
        end
    endtask

    task automatic drain2(input logic spot);
        exp_t e;
        int   budget = 0;
        while (q2.size() > 0 && budget < 2000) begin
            e = q2[0];
            chk("vld2", {63'h0, bus2.expnd_otpt_vld_o}, 64'd1);
            chk("idx2", {58'h0, bus2.expnd_otpt_idx_o}, {58'h0, e.idx});
            chk("wj2", bus2.expnd_otpt_wj_o, e.wj);
            chk("wjj2", bus2.expnd_otpt_wjj_o, e.wjj);
            chk("lst2", {63'h0, bus2.expnd_otpt_lst_o}, {63'h0, e.lst});
            if (spot && e.idx == 6'd16) chk("abc2_beat16", bus2.expnd_otpt_wj_o, 64'h9092e200_00000000);
            bus2.expnd_otpt_ena_i = 1'b1;
            void'(q2.pop_front());
            @(negedge clk);
            budget++;
        end
        bus2.expnd_otpt_ena_i = 1'b0;
        chk("drain2_done", 64'(q2.size()), 64'd0);
        chk("drain2_rdy", {63'h0, bus2.pad_inpt_rdy_o}, 64'd1);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        #1;
        chk("rst_vld", {63'h0, bus1.expnd_otpt_vld_o}, 64'd0);
        chk("rst_rdy", {63'h0, bus1.pad_inpt_rdy_o}, 64'd1);
        chk("rst_lst", {63'h0, bus1.expnd_otpt_lst_o}, 64'd0);
        chk("rst_wj", {32'h0, bus1.expnd_otpt_wj_o}, 64'd0);
        chk("rst_idx", {58'h0, bus1.expnd_otpt_idx_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        bus1.pad_inpt_d_i = '0; bus1.pad_inpt_vld_i = 1'b0; bus1.pad_inpt_lst_i = 1'b0; bus1.expnd_otpt_ena_i = 1'b0;
        bus2.pad_inpt_d_i = '0; bus2.pad_inpt_vld_i = 1'b0; bus2.pad_inpt_lst_i = 1'b0; bus2.expnd_otpt_ena_i = 1'b0;

        // Reset state
        @(negedge clk);
        rst_pulse();
        chk("rst2_rdy", {63'h0, bus2.pad_inpt_rdy_o}, 64'd1);
        chk("rst2_vld", {63'h0, bus2.expnd_otpt_vld_o}, 64'd0);
        chk("rst2_wjj", bus2.expnd_otpt_wjj_o, 64'd0);

        // "abc", 1/1, ena held high: 80 cycles per block
        set_abc(); build_ref(); push1(1'b1);
        c0 = cyc;
        load1(1'b1, 1'b0, -1);
        drain1(1'b0, 1'b1, -1);
        chk("abc1_cycles", 64'(cyc - c0), 64'd80);

        // "abc", 2/2: 40 cycles per block
        push2(1'b1);
        c0 = cyc;
        load2(1'b1);
        drain2(1'b1);
        chk("abc2_cycles", 64'(cyc - c0), 64'd40);

        // Two random blocks under 50% back-pressure; stray lst on word 4 ignored
        set_rand(); build_ref(); push1(1'b0);
        load1(1'b0, 1'b0, 4);
        drain1(1'b1, 1'b0, -1);
        set_rand(); build_ref(); push1(1'b1);
        load1(1'b1, 1'b0, -1);
        drain1(1'b1, 1'b0, -1);

        // Reset mid-expansion at idx 30, then a clean block
        set_rand(); build_ref(); push1(1'b1);
        load1(1'b1, 1'b0, -1);
        drain1(1'b0, 1'b0, 30);
        rst_pulse();
        q1.delete();
        set_rand(); build_ref(); push1(1'b1);
        load1(1'b1, 1'b0, -1);
        drain1(1'b0, 1'b0, -1);

        // Input gaps: must match the gap-free "abc" result
        set_abc(); build_ref(); push1(1'b1);
        load1(1'b1, 1'b1, -1);
        drain1(1'b0, 1'b1, -1);

`ifdef SM3_EXPND_ERR_CHK_EN
        rst_pulse();
        chk("err_clear", {63'h0, err1}, 64'd0);
        set_abc(); build_ref(); push1(1'b1);
        load1(1'b1, 1'b0, 4);
        drain1(1'b0, 1'b1, -1);
        chk("err_sticky", {63'h0, err1}, 64'd1);
        rst_pulse();
        chk("err_rst", {63'h0, err1}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
